instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes structured instruction requests (operation select plus register, shift and immediate fields) into 32-bit instruction words and writes them sequentially into instruction memory through a single write port. It is the encoding counterpart of the core's control decoder: every word it emits decodes back to the intended control settings. It sits between the program-load / self-test sequencer and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction memory address width in words.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; loads base_addr, clears counters and errors, and enters RUN.
- base_addr  in  ADDR_W  first write address.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  5  operation select.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_shamt  in  5  shift amount.
- in_imm  in  26  signed immediate, or jump target.
- in_last  in  1  marks the final instruction of a program.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  high in RUN or WRITE.
- done  out  1  sticky; set after in_last is written; cleared by start.
- err  out  1  sticky error; cleared by start.
- err_code  out  2  error cause: 01 illegal op, 10 immediate out of range, 11 memory full.
- word_count  out  ADDR_W+1  number of words written since start.

## Operation

**Word formats**
- R-format: [31:26]=0, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=shamt, [5:0]=funct.
- I-format: opcode, rs, rt, [15:0]=imm[15:0].
- J-format: opcode, [25:0]=imm.
- Any field not used by an op is encoded as 0.

**Op map (R-format, funct value)**
- Field use: shamt is encoded only for ops 4, 5 and 8; op 10 encodes rs only.
- 0 ADD, funct 32.
- 1 COMP, funct 34.
- 2 AND, funct 42.
- 3 XOR, funct 36.
- 4 SLL, funct 31.
- 5 SRL, funct 30.
- 6 SLLV, funct 37.
- 7 SRLV, funct 38.
- 8 SRA, funct 29.
- 9 SRAV, funct 39.
- 10 JR, funct 8.

**Op map (I-format, opcode)**
- 11 ADDI, 001100.
- 12 COMPI, 001101.
- 13 LW, 100011.
- 14 SW, 101011.
- 17 BR1, 000100.
- 18 BR2, 000101.

**Op map (J-format, opcode)**
- 15 J, 000010.
- 16 BR0, 000001.
- 19 JAL, 000011.
- 20 BR3, 001111.
- 21 BR4, 010000.
- Ops 22..31 are illegal.

**Checks**
- I-format: in_imm[25:15] must be all 0s or all 1s (signed 16-bit range); otherwise error 10.
- An illegal op gives error 01.
- On any error, no write is issued.

**State machine**
- IDLE: in_ready=0. start → RUN.
- RUN: in_ready=1. On in_valid&in_ready, register the encoded word, address and in_last.
  - Request legal → WRITE.
  - Request illegal or out of range → ERR, with err/err_code set the next cycle.
- WRITE: imem_we=1 for exactly one cycle, driving imem_addr and imem_wdata. word_count increments and the address increments modulo 2^ADDR_W.
  - in_last=1 → DONE.
  - Else, written address was all-ones → ERR with code 11 (memory full; no wrap).
  - Else → RUN.
- DONE, ERR: in_ready=0, busy=0. start → RUN.
- start has priority in every state. A start in WRITE drops the pending write: imem_we=0 that cycle.
- When the same cycle has both start and in_valid, start wins and the request is not accepted.

## Timing
- Reset values: state IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, err_code, word_count = 0.
- All outputs are registered.
- Accept at cycle n → imem_we high at cycle n+1 → in_ready high again at cycle n+2. Peak throughput is one word per 2 cycles.
- start at cycle n → in_ready=1 and busy=1 at n+1, with word_count=0.
- done and err assert in the cycle after the transition into DONE or ERR.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- rst mid-write suppresses the write in that cycle and returns to IDLE.

## Test plan
- start, base 0x10. Submit ADD rs=1 rt=2 rd=3, last=1 → imem_we at addr 0x10, data 0x00221820. Then done=1, word_count=1.
- Back-to-back requests: LW rs=29 rt=4 imm=-4 (data 0x8FA4FFFC), SLL rt=6 rd=5 shamt=4 (data 0x0006291F), J imm=0x40 (data 0x08000040), last on J → consecutive addresses. Check in_ready low in each WRITE cycle.
- in_op=25 → err=1, err_code=01, no imem_we, in_ready=0 until start.
- ADDI imm=32768 → err_code=10, no write. Repeat with imm=-32768 → accepted; data low half 0x8000.
- ADDR_W=2, base 2, three non-last requests → writes at 2 and 3, then err_code=11, word_count=2, third request not accepted.
- start asserted in the WRITE cycle → no write. Also rst during RUN → all outputs at their reset values next cycle.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory write port of the instruction encoder.
// The sequencer side uses master, the encoder uses slave.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit R/I/J words and writes them sequentially into
// instruction memory, one word per two cycles, with sticky done/error reporting.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  instr_encoder_if.slave    bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W:0]   word_count_o
);

  typedef enum logic [2:0] {StIdle, StRun, StWrite, StDone, StErr} state_e;
  typedef enum logic [1:0] {FmtR, FmtI, FmtJ, FmtBad} fmt_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  fmt_e        fmt;
  logic [5:0]  funct, opcode;
  logic [31:0] enc_word;
  logic        imm_ok;
  logic [1:0]  req_code;

  always_comb begin
    fmt    = FmtBad;
    funct  = 6'd0;
    opcode = 6'd0;
    case (bus.in_op)
      5'd0:  begin fmt = FmtR; funct = 6'd32; end
      5'd1:  begin fmt = FmtR; funct = 6'd34; end
      5'd2:  begin fmt = FmtR; funct = 6'd42; end
      5'd3:  begin fmt = FmtR; funct = 6'd36; end
      5'd4:  begin fmt = FmtR; funct = 6'd31; end
      5'd5:  begin fmt = FmtR; funct = 6'd30; end
      5'd6:  begin fmt = FmtR; funct = 6'd37; end
      5'd7:  begin fmt = FmtR; funct = 6'd38; end
      5'd8:  begin fmt = FmtR; funct = 6'd29; end
      5'd9:  begin fmt = FmtR; funct = 6'd39; end
      5'd10: begin fmt = FmtR; funct = 6'd8;  end
      5'd11: begin fmt = FmtI; opcode = 6'b001100; end
      5'd12: begin fmt = FmtI; opcode = 6'b001101; end
      5'd13: begin fmt = FmtI; opcode = 6'b100011; end
      5'd14: begin fmt = FmtI; opcode = 6'b101011; end
      5'd15: begin fmt = FmtJ; opcode = 6'b000010; end
      5'd16: begin fmt = FmtJ; opcode = 6'b000001; end
      5'd17: begin fmt = FmtI; opcode = 6'b000100; end
      5'd18: begin fmt = FmtI; opcode = 6'b000101; end
      5'd19: begin fmt = FmtJ; opcode = 6'b000011; end
      5'd20: begin fmt = FmtJ; opcode = 6'b001111; end
      5'd21: begin fmt = FmtJ; opcode = 6'b010000; end
      default: ;
    endcase
  end

  // Unused fields stay zero: JR carries rs only, shamt only for the immediate shifts.
  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FmtR: begin
        enc_word[25:21] = bus.in_rs;
        if (bus.in_op != 5'd10) begin
          enc_word[20:16] = bus.in_rt;
          enc_word[15:11] = bus.in_rd;
        end
        if (bus.in_op == 5'd4 || bus.in_op == 5'd5 || bus.in_op == 5'd8) begin
          enc_word[10:6] = bus.in_shamt;
        end
        enc_word[5:0] = funct;
      end
      FmtI:    enc_word = {opcode, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      FmtJ:    enc_word = {opcode, bus.in_imm};
      default: ;
    endcase
  end

  assign imm_ok   = (&bus.in_imm[25:15]) | ~(|bus.in_imm[25:15]);
  assign req_code = (fmt == FmtBad)            ? 2'b01 :
                    (fmt == FmtI && !imm_ok)   ? 2'b10 : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = StRun;
    end else begin
      case (state_q)
        StRun:   if (bus.in_valid) state_d = (req_code == 2'b00) ? StWrite : StErr;
        StWrite: begin
          if (last_q)        state_d = StDone;
          else if (&waddr_q) state_d = StErr;
          else               state_d = StRun;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_d     = addr_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    count_d    = count_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    if (start_i) begin
      addr_d     = base_addr_i;
      last_d     = 1'b0;
      count_d    = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end else begin
      case (state_q)
        StRun: begin
          if (bus.in_valid) begin
            if (req_code == 2'b00) begin
              waddr_d = addr_q;
              wdata_d = enc_word;
              last_d  = bus.in_last;
            end else begin
              err_d      = 1'b1;
              err_code_d = req_code;
            end
          end
        end
        StWrite: begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (last_q) begin
            done_d = 1'b1;
          end else if (&waddr_q) begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      last_q     <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      addr_q     <= addr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // A start or reset arriving during WRITE must cancel that cycle's strobe.
  assign bus.imem_we    = (state_q == StWrite) & ~start_i & ~rst_i;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.in_ready   = (state_q == StRun);
  assign busy_o         = (state_q == StRun) | (state_q == StWrite);
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;
  assign word_count_o   = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: a default-width instance and a
// 2-bit-address instance for the memory-full case.
module tb_instr_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] base8 = 8'd0;
  logic [1:0] base2 = 2'd0;
  logic       busy8, done8, err8, busy2, done2, err2;
  logic [1:0] code8, code2;
  logic [8:0] cnt8;
  logic [2:0] cnt2;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr8 = 0;
  int         wr2 = 0;

  instr_encoder_if #(.ADDR_W(8)) if8 ();
  instr_encoder_if #(.ADDR_W(2)) if2 ();

  instr_encoder #(.ADDR_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .base_addr_i(base8), .bus(if8),
    .busy_o(busy8), .done_o(done8), .err_o(err8), .err_code_o(code8), .word_count_o(cnt8)
  );

  instr_encoder #(.ADDR_W(2)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .base_addr_i(base2), .bus(if2),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .err_code_o(code2), .word_count_o(cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if8.imem_we) wr8++;
    if (if2.imem_we) wr2++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                         input logic last);
    if8.in_op = op;   if8.in_rs = rs; if8.in_rt = rt; if8.in_rd = rd;
    if8.in_shamt = sh; if8.in_imm = imm; if8.in_last = last;
    if2.in_op = op;   if2.in_rs = rs; if2.in_rt = rt; if2.in_rd = rd;
    if2.in_shamt = sh; if2.in_imm = imm; if2.in_last = last;
  endtask

  // Present one request to the wide DUT for one accept edge.
  task automatic issue8(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                        input logic last);
    set_req(op, rs, rt, rd, sh, imm, last);
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
  endtask

  task automatic start_wide(input logic [7:0] base);
    base8  = base;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  initial begin
    if8.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", {31'd0, if8.in_ready}, 32'd0);
    chk("rst_we", {31'd0, if8.imem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done_err", {30'd0, done8, err8}, 32'd0);
    chk("rst_addr", {24'd0, if8.imem_addr}, 32'd0);
    chk("rst_wdata", if8.imem_wdata, 32'd0);
    chk("rst_code_cnt", {21'd0, code8, cnt8}, 32'd0);
    chk("rst_small_ready", {31'd0, if2.in_ready}, 32'd0);

    // Single ADD with last
    start_wide(8'h10);
    chk("t1_ready", {31'd0, if8.in_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy8}, 32'd1);
    chk("t1_cnt0", {23'd0, cnt8}, 32'd0);
    issue8(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1);
    chk("t1_we", {31'd0, if8.imem_we}, 32'd1);
    chk("t1_addr", {24'd0, if8.imem_addr}, 32'h10);
    chk("t1_data", if8.imem_wdata, 32'h0022_1820);
    chk("t1_wr_ready", {31'd0, if8.in_ready}, 32'd0);
    tick();
    chk("t1_done", {31'd0, done8}, 32'd1);
    chk("t1_cnt", {23'd0, cnt8}, 32'd1);
    chk("t1_busy_off", {31'd0, busy8}, 32'd0);
    chk("t1_we_off", {31'd0, if8.imem_we}, 32'd0);
    chk("t1_addr_hold", {24'd0, if8.imem_addr}, 32'h10);

    // Back-to-back LW, SLL, J(last)
    start_wide(8'h20);
    issue8(5'd13, 5'd29, 5'd4, 5'd0, 5'd0, 26'h3FF_FFFC, 1'b0);
    chk("t2_lw_we", {31'd0, if8.imem_we}, 32'd1);
    chk("t2_lw_addr", {24'd0, if8.imem_addr}, 32'h20);
    chk("t2_lw_data", if8.imem_wdata, 32'h8FA4_FFFC);
    chk("t2_lw_ready", {31'd0, if8.in_ready}, 32'd0);
    tick();
    chk("t2_ready_back", {31'd0, if8.in_ready}, 32'd1);
    issue8(5'd4, 5'd0, 5'd6, 5'd5, 5'd4, 26'd0, 1'b0);
    chk("t2_sll_addr", {24'd0, if8.imem_addr}, 32'h21);
    chk("t2_sll_data", if8.imem_wdata, 32'h0006_291F);
    chk("t2_sll_ready", {31'd0, if8.in_ready}, 32'd0);
    tick();
    issue8(5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 26'h40, 1'b1);
    chk("t2_j_addr", {24'd0, if8.imem_addr}, 32'h22);
    chk("t2_j_data", if8.imem_wdata, 32'h0800_0040);
    chk("t2_j_we", {31'd0, if8.imem_we}, 32'd1);
    tick();
    chk("t2_done_cnt", {22'd0, done8, cnt8}, {22'd0, 1'b1, 9'd3});
    chk("t2_writes", wr8, 32'd4);

    // Illegal op
    start_wide(8'h40);
    issue8(5'd25, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, 1'b0);
    chk("t3_err", {31'd0, err8}, 32'd1);
    chk("t3_code", {30'd0, code8}, 32'd1);
    chk("t3_we", {31'd0, if8.imem_we}, 32'd0);
    chk("t3_ready", {31'd0, if8.in_ready}, 32'd0);
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    chk("t3_ready_hold", {31'd0, if8.in_ready}, 32'd0);
    chk("t3_writes", wr8, 32'd4);

    // Immediate range boundary
    start_wide(8'h50);
    chk("t4_err_cleared", {29'd0, err8, code8}, 32'd0);
    issue8(5'd11, 5'd2, 5'd1, 5'd0, 5'd0, 26'h000_8000, 1'b0);
    chk("t4_code_range", {30'd0, code8}, 32'd2);
    chk("t4_we_range", {31'd0, if8.imem_we}, 32'd0);
    start_wide(8'h50);
    issue8(5'd11, 5'd2, 5'd1, 5'd0, 5'd0, 26'h3FF_8000, 1'b0);
    chk("t4_we_neg", {31'd0, if8.imem_we}, 32'd1);
    chk("t4_data_neg", if8.imem_wdata, 32'h3041_8000);
    chk("t4_err_neg", {31'd0, err8}, 32'd0);
    tick();
    chk("t4_writes", wr8, 32'd5);

    // Memory full on the 2-bit address instance
    base2  = 2'd2;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if2.in_valid = 1'b1;
      tick();
      if2.in_valid = 1'b0;
      chk("t5_addr", {30'd0, if2.imem_addr}, 32'(2 + i));
      chk("t5_we", {31'd0, if2.imem_we}, 32'd1);
      tick();
    end
    chk("t5_err", {31'd0, err2}, 32'd1);
    chk("t5_code", {30'd0, code2}, 32'd3);
    chk("t5_cnt", {29'd0, cnt2}, 32'd2);
    if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    chk("t5_ready", {31'd0, if2.in_ready}, 32'd0);
    tick();
    chk("t5_writes", wr2, 32'd2);

    // start in WRITE drops the write
    start_wide(8'h60);
    issue8(5'd1, 5'd3, 5'd3, 5'd3, 5'd0, 26'd0, 1'b0);
    start8 = 1'b1;
    #1;
    chk("t6_we_drop", {31'd0, if8.imem_we}, 32'd0);
    tick();
    start8 = 1'b0;
    chk("t6_ready", {31'd0, if8.in_ready}, 32'd1);
    chk("t6_cnt", {23'd0, cnt8}, 32'd0);
    chk("t6_writes", wr8, 32'd5);

    // rst mid-write, then outputs return to reset values
    issue8(5'd2, 5'd7, 5'd8, 5'd9, 5'd0, 26'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t7_we_rst", {31'd0, if8.imem_we}, 32'd0);
    tick();
    chk("t7_ready", {31'd0, if8.in_ready}, 32'd0);
    chk("t7_busy", {31'd0, busy8}, 32'd0);
    chk("t7_addr", {24'd0, if8.imem_addr}, 32'd0);
    chk("t7_wdata", if8.imem_wdata, 32'd0);
    chk("t7_flags", {19'd0, done8, err8, code8, cnt8}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t7_writes", wr8, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
